// File: rtl/ysyx_22040931_ifu_bp_if.sv
// Instruction-memory fetch handshake between the fetch stage and memory.
//   inst_req   : fetch request (fetch -> memory)
//   inst_addr  : fetch address, stable while a request is outstanding
//   inst_valid : one-cycle response strobe (memory -> fetch)
//   inst_rdata : instruction word, valid with inst_valid
interface ysyx_22040931_ifu_bp_if #(
  parameter int PC_W = 64
);
  logic            inst_req;
  logic [PC_W-1:0] inst_addr;
  logic            inst_valid;
  logic [31:0]     inst_rdata;

  modport master (output inst_req, output inst_addr, input inst_valid, input inst_rdata);
  modport slave  (input inst_req, input inst_addr, output inst_valid, output inst_rdata);
endinterface

// File: rtl/ysyx_22040931_ifu_bp.sv
// Instruction-fetch stage with a direct-mapped BTB and 2-bit direction
// counters. Owns the fetch PC, drives the instruction-memory handshake and
// presents the fetched instruction plus its prediction to decode. Decode's
// resolved-branch feedback trains the BTB and redirects fetch.
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   imem              : instruction-memory handshake (master side)
//   stall_i           : decode load-stall; outputs hold while high
//   valid_o/pc_o/instr_o/pre_jump_o/pre_branch_o : to decode
//   id_valid/id_pc/id_jumptype/id_taken/id_target/id_error_pre : from decode
module ysyx_22040931_ifu_bp #(
  parameter int              PC_W     = 64,
  parameter int              BTB_IDX  = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000),
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_22040931_ifu_bp_if.master imem,
  input  logic                  stall_i,
  output logic                  valid_o,
  output logic [PC_W-1:0]       pc_o,
  output logic [31:0]           instr_o,
  output logic                  pre_jump_o,
  output logic [PC_W-1:0]       pre_branch_o,
  input  logic                  id_valid,
  input  logic [PC_W-1:0]       id_pc,
  input  logic [1:0]            id_jumptype,
  input  logic                  id_taken,
  input  logic [PC_W-1:0]       id_target,
  input  logic                  id_error_pre
);

  localparam int ENTRIES = 1 << BTB_IDX;
  localparam int TAG_W   = PC_W - BTB_IDX - 2;

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_KILL = 2'd3;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            pj;
    logic [PC_W-1:0] pb;
  } fetch_t;

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  fetch_t          skid;
  fetch_t          cur;

  // BTB storage; only valid bits and counters need a reset value
  logic [ENTRIES-1:0]            btb_vld;
  logic [ENTRIES-1:0][1:0]       btb_cnt;
  logic [ENTRIES-1:0][TAG_W-1:0] btb_tag;
  logic [ENTRIES-1:0][PC_W-1:0]  btb_tgt;

  // ---------------- lookup on the current fetch PC ----------------
  logic [BTB_IDX-1:0] lk_idx;
  logic               lk_hit;
  logic               pre_jump;
  logic [PC_W-1:0]    pre_tgt;
  logic [PC_W-1:0]    next_pc;

  assign lk_idx   = pc[BTB_IDX+1:2];
  assign lk_hit   = btb_vld[lk_idx] && (btb_tag[lk_idx] == pc[PC_W-1:BTB_IDX+2]);
  assign pre_jump = lk_hit && btb_cnt[lk_idx][1];
  assign pre_tgt  = pre_jump ? btb_tgt[lk_idx] : '0;
  assign next_pc  = pre_jump ? btb_tgt[lk_idx] : pc + PC_W'(4);

  assign cur = '{pc: pc, instr: imem.inst_rdata, pj: pre_jump, pb: pre_tgt};

  // ---------------- decode feedback ----------------
  logic               fb;
  logic               redirect;
  logic [PC_W-1:0]    redir_pc;
  logic               train;
  logic [BTB_IDX-1:0] tr_idx;
  logic               tr_hit;
  logic [1:0]         tr_cnt;
  logic [1:0]         cnt_inc;
  logic [1:0]         cnt_dec;

  // a stalled decode slot is not a real resolution, so it is ignored
  assign fb       = id_valid && !stall_i;
  assign redirect = fb && id_error_pre;
  assign redir_pc = id_taken ? id_target : id_pc + PC_W'(4);

  assign train   = fb && (id_jumptype != 2'b00);
  assign tr_idx  = id_pc[BTB_IDX+1:2];
  assign tr_hit  = btb_vld[tr_idx] && (btb_tag[tr_idx] == id_pc[PC_W-1:BTB_IDX+2]);
  assign tr_cnt  = btb_cnt[tr_idx];
  assign cnt_inc = (tr_cnt == 2'b11) ? 2'b11 : tr_cnt + 2'b01;
  assign cnt_dec = (tr_cnt == 2'b00) ? 2'b00 : tr_cnt - 2'b01;

  // Training happens alongside lookup; the lookup above sees the table
  // as it was before this edge (no bypass).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btb_vld <= '0;
      btb_cnt <= {ENTRIES{2'b01}};
    end else if (train) begin
      if (id_taken) begin
        btb_vld[tr_idx] <= 1'b1;
        btb_cnt[tr_idx] <= tr_hit ? cnt_inc : 2'b10;
      end else if (tr_hit) begin
        btb_cnt[tr_idx] <= cnt_dec;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (train && id_taken) begin
      btb_tag[tr_idx] <= id_pc[PC_W-1:BTB_IDX+2];
      btb_tgt[tr_idx] <= id_target;
    end
  end

  // ---------------- fetch FSM and output register ----------------
  assign imem.inst_req  = (state == S_REQ);
  assign imem.inst_addr = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_RST;
      pc           <= RESET_PC;
      skid         <= '0;
      valid_o      <= 1'b0;
      pc_o         <= '0;
      instr_o      <= NOP;
      pre_jump_o   <= 1'b0;
      pre_branch_o <= '0;
    end else begin
      // bubble unless an instruction is loaded below; a stall freezes all
      if (!stall_i) begin
        valid_o <= 1'b0;
        instr_o <= NOP;
      end
      case (state)
        S_RST: begin
          state <= S_REQ;
          if (redirect) pc <= redir_pc;
        end
        S_REQ: begin
          if (imem.inst_valid) begin
            if (stall_i) begin
              // decode can't take it: park in the skid buffer, stop requesting
              skid  <= cur;
              pc    <= next_pc;
              state <= S_HOLD;
            end else if (redirect) begin
              pc <= redir_pc;
            end else begin
              valid_o      <= 1'b1;
              pc_o         <= cur.pc;
              instr_o      <= cur.instr;
              pre_jump_o   <= cur.pj;
              pre_branch_o <= cur.pb;
              pc           <= next_pc;
            end
          end else if (redirect) begin
            // the in-flight response belongs to the wrong path; swallow it
            pc    <= redir_pc;
            state <= S_KILL;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            state <= S_REQ;
            if (redirect) begin
              pc   <= redir_pc;
              skid <= '0;
            end else begin
              valid_o      <= 1'b1;
              pc_o         <= skid.pc;
              instr_o      <= skid.instr;
              pre_jump_o   <= skid.pj;
              pre_branch_o <= skid.pb;
            end
          end
        end
        S_KILL: begin
          if (redirect) pc <= redir_pc;
          if (imem.inst_valid) state <= S_REQ;
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_ifu_bp.sv
module tb_ysyx_22040931_ifu_bp;
  localparam int          PC_W   = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        valid_o;
  logic [63:0] pc_o;
  logic [31:0] instr_o;
  logic        pre_jump_o;
  logic [63:0] pre_branch_o;
  logic        id_valid = 1'b0;
  logic [63:0] id_pc = '0;
  logic [1:0]  id_jumptype = 2'b00;
  logic        id_taken = 1'b0;
  logic [63:0] id_target = '0;
  logic        id_error_pre = 1'b0;

  always #5 clock = ~clock;

  ysyx_22040931_ifu_bp_if #(.PC_W(PC_W)) imem ();

  ysyx_22040931_ifu_bp dut (
    .clock(clock), .reset(reset), .imem(imem.master), .stall_i(stall_i),
    .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o), .pre_jump_o(pre_jump_o),
    .pre_branch_o(pre_branch_o), .id_valid(id_valid), .id_pc(id_pc),
    .id_jumptype(id_jumptype), .id_taken(id_taken), .id_target(id_target),
    .id_error_pre(id_error_pre)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;

  // fetch-level model: where fetch should go next, what decode should see
  bit          m_started, m_kill, m_buf;
  logic [63:0] m_pc;
  bit          e_vld, e_pj;
  logic [63:0] e_pc, e_pb;
  logic [31:0] e_instr;
  bit          b_pj;
  logic [63:0] b_pc, b_pb;
  logic [31:0] b_instr;
  // BTB model keyed by the word address of the branch that owns each slot
  bit          bv[16];
  logic [61:0] bo[16];
  logic [63:0] btg[16];
  int          bc[16];
  // memory model
  bit          mb;
  int          mcnt;
  logic [63:0] maddr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0093;
    if (a == 64'h8000_0004) return 32'h0020_0113;
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    m_started = 0; m_kill = 0; m_buf = 0; m_pc = RST_PC;
    e_vld = 0; e_pj = 0; e_pc = '0; e_pb = '0; e_instr = NOP;
    for (int i = 0; i < 16; i++) begin
      bv[i] = 0; bc[i] = 1; bo[i] = '0; btg[i] = '0;
    end
    mb = 0; mcnt = 0; maddr = '0;
  endtask

  task automatic check_outs();
    chk("inst_req", {63'd0, imem.inst_req}, {63'd0, m_started && !m_kill && !m_buf});
    chk("inst_addr", imem.inst_addr, m_pc);
    chk("valid_o", {63'd0, valid_o}, {63'd0, e_vld});
    chk("pc_o", pc_o, e_pc);
    chk("instr_o", {32'd0, instr_o}, {32'd0, (e_vld ? e_instr : NOP)});
    chk("pre_jump_o", {63'd0, pre_jump_o}, {63'd0, e_pj});
    chk("pre_branch_o", pre_branch_o, e_pb);
  endtask

  // one clock cycle, entered and left at a falling edge
  task automatic tick(input bit st, input bit fv, input logic [1:0] jt, input bit tk,
                      input logic [63:0] ipc, input logic [63:0] itg, input bit err,
                      input int lat);
    bit iv, fb, rd, hit, pj, busy0, h;
    logic [63:0] rpc, pb, npc;
    int idx, ti;
    stall_i = st; id_valid = fv; id_jumptype = jt; id_taken = tk;
    id_pc = ipc; id_target = itg; id_error_pre = err;
    iv = mb && (mcnt == 0);
    imem.inst_valid = iv;
    imem.inst_rdata = iv ? mem_word(maddr) : $urandom;

    fb  = fv && !st;
    rd  = fb && err;
    rpc = tk ? itg : ipc + 64'd4;
    idx = int'(m_pc[5:2]);
    hit = bv[idx] && (bo[idx] == m_pc[63:2]);
    pj  = hit && (bc[idx] >= 2);
    pb  = pj ? btg[idx] : 64'd0;
    npc = pj ? btg[idx] : m_pc + 64'd4;

    if (!st) e_vld = 0;
    if (!m_started) begin
      m_started = 1;
      if (rd) m_pc = rpc;
    end else if (m_kill) begin
      if (rd) m_pc = rpc;
      if (iv) m_kill = 0;
    end else if (m_buf) begin
      if (!st) begin
        m_buf = 0;
        if (rd) m_pc = rpc;
        else begin
          e_vld = 1; e_pc = b_pc; e_instr = b_instr; e_pj = b_pj; e_pb = b_pb; n_acc++;
        end
      end
    end else if (iv) begin
      if (st) begin
        m_buf = 1; b_pc = m_pc; b_instr = mem_word(m_pc); b_pj = pj; b_pb = pb; m_pc = npc;
      end else if (rd) begin
        m_pc = rpc;
      end else begin
        e_vld = 1; e_pc = m_pc; e_instr = mem_word(m_pc); e_pj = pj; e_pb = pb;
        m_pc = npc; n_acc++;
      end
    end else if (rd) begin
      m_pc = rpc; m_kill = 1;
    end

    if (fb && jt != 2'b00) begin
      ti = int'(ipc[5:2]);
      h  = bv[ti] && (bo[ti] == ipc[63:2]);
      if (tk) begin
        bc[ti] = h ? ((bc[ti] == 3) ? 3 : bc[ti] + 1) : 2;
        bv[ti] = 1; bo[ti] = ipc[63:2]; btg[ti] = itg;
      end else if (h) begin
        bc[ti] = (bc[ti] == 0) ? 0 : bc[ti] - 1;
      end
    end

    busy0 = mb;
    if (iv) mb = 0;
    else if (mb) mcnt--;
    if (!busy0 && imem.inst_req) begin
      mb = 1; mcnt = lat - 1; maddr = imem.inst_addr;
    end

    @(posedge clock);
    @(negedge clock);
    check_outs();
  endtask

  task automatic idle(input int n, input int lat);
    for (int i = 0; i < n; i++) tick(0, 0, 2'b00, 0, '0, '0, 0, lat);
  endtask

  function automatic logic [63:0] near_pc(input int span);
    return RST_PC + 64'(4 * $urandom_range(0, span));
  endfunction

  initial begin
    bit ok;
    imem.inst_valid = 1'b0;
    imem.inst_rdata = '0;
    model_init();

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_outs();
    end
    reset = 1'b1;

    // sequential fetch with 1-cycle memory
    idle(6, 1);

    // train a taken branch at 0x10, then let fetch reach it
    tick(0, 1, 2'b01, 1, 64'h8000_0010, 64'h8000_0040, 0, 1);
    idle(12, 1);
    // back to 0x10, train not-taken twice, fetch it again
    tick(0, 1, 2'b00, 1, 64'h8000_0000, 64'h8000_0010, 1, 1);
    tick(0, 1, 2'b01, 0, 64'h8000_0010, 64'h0, 0, 1);
    tick(0, 1, 2'b01, 0, 64'h8000_0010, 64'h0, 0, 1);
    tick(0, 1, 2'b00, 1, 64'h8000_0000, 64'h8000_0010, 1, 1);
    idle(6, 1);

    // redirect while a 3-cycle request is pending
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mb && mcnt > 0) ok = 1;
      else idle(1, 3);
    end
    chk("wait_pending", {63'd0, ok}, 64'd1);
    tick(0, 1, 2'b11, 1, 64'h8000_0020, 64'h8000_0100, 1, 3);
    idle(12, 3);

    // stall for three cycles with the response in the first
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mb && mcnt == 0) ok = 1;
      else idle(1, 1);
    end
    chk("wait_resp", {63'd0, ok}, 64'd1);
    for (int i = 0; i < 3; i++) tick(1, 0, 2'b00, 0, '0, '0, 0, 1);
    idle(4, 1);

    // feedback under stall must be ignored
    tick(1, 1, 2'b01, 1, 64'h8000_0030, 64'h8000_0200, 1, 1);
    idle(6, 1);

    // PC wrap across the top of the address space
    tick(0, 1, 2'b10, 1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
    idle(8, 1);
    tick(0, 1, 2'b10, 1, 64'h8000_0000, RST_PC, 1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit st, fv, tk, er;
      logic [1:0] jt;
      logic [63:0] ipc, itg;
      st  = ($urandom_range(0, 3) == 0);
      fv  = ($urandom_range(0, 1) == 1);
      jt  = 2'($urandom_range(0, 3));
      tk  = ($urandom_range(0, 1) == 1);
      er  = ($urandom_range(0, 6) == 0);
      ipc = near_pc(31);
      itg = near_pc(63);
      tick(st, fv, jt, tk, ipc, itg, er, $urandom_range(1, 3));
    end
    chk("progress", {63'd0, n_acc > 200}, 64'd1);

    // asynchronous reset in the middle of a transaction
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mb && mcnt > 0) ok = 1;
      else idle(1, 3);
    end
    chk("wait_pending2", {63'd0, ok}, 64'd1);
    stall_i = 0; id_valid = 0; id_error_pre = 0; id_jumptype = 2'b00;
    reset = 1'b0;
    model_init();
    #1;
    check_outs();
    // the late response of the killed request shows up during reset
    @(negedge clock);
    imem.inst_valid = 1'b1;
    imem.inst_rdata = 32'hDEAD_BEEF;
    @(posedge clock);
    @(negedge clock);
    check_outs();
    imem.inst_valid = 1'b0;
    @(negedge clock);
    check_outs();
    reset = 1'b1;
    idle(8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ysyx_22040931_ifu_bp.md
# ysyx_22040931_ifu_bp

Instruction-fetch stage with a direct-mapped branch target buffer and 2-bit direction predictor, sitting directly upstream of the decode stage. It owns the fetch PC and drives the instruction-memory request/response handshake. It presents `pc_o`, `instr_o`, `pre_jump_o` and `pre_branch_o` to decode. It redirects fetch and trains the predictor from decode's resolved-branch feedback.

## Interface
- `PC_W`, 64: PC and target width.
- `BTB_IDX`, 4: index bits; the table has 2^BTB_IDX entries, indexed by `pc[BTB_IDX+1:2]`.
- `RESET_PC`, 64'h8000_0000: first fetch address.
- `NOP`, 32'h0000_0013: value of `instr_o` when not valid.

Ports:
- `clock` in 1: the single clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `inst_req` out 1: fetch request.
- `inst_addr` out PC_W: fetch address; held stable while `inst_req`=1 and no response has arrived.
- `inst_valid` in 1: response strobe; latency ≥1 cycle after `inst_req`.
- `inst_rdata` in 32: instruction data, valid when `inst_valid`=1.
- `stall_i` in 1: decode load-stall; when high, outputs hold.
- `valid_o` out 1: the instruction on the outputs is live.
- `pc_o` out PC_W: PC of the instruction on `instr_o`.
- `instr_o` out 32: fetched instruction.
- `pre_jump_o` out 1: predicted taken.
- `pre_branch_o` out PC_W: predicted target; 0 when not taken.
- `id_valid` in 1: decode holds a live instruction.
- `id_pc` in PC_W: decode-stage PC.
- `id_jumptype` in 2: 00 = none, 01 = B-type, 10 = JAL, 11 = taken JALR.
- `id_taken` in 1: resolved direction.
- `id_target` in PC_W: resolved target.
- `id_error_pre` in 1: misprediction.

## Operation
- **Feedback qualification.** `fb = id_valid & ~stall_i`. When `fb`=0, all decode feedback is ignored.
- **Prediction.** Lookup uses the current fetch PC. A BTB hit requires `valid[idx]` and `tag[idx] == pc[PC_W-1:BTB_IDX+2]`.
  - `pre_jump` = hit & `cnt[idx][1]`.
  - `pre_branch` = `pre_jump` ? `tgt[idx]` : 0.
  - Next PC = `pre_jump` ? `tgt[idx]` : pc+4, computed mod 2^PC_W with wrap allowed.
  - Prediction values are captured with the instruction when the response is accepted.
- **Training.** Applies when `fb` & `id_jumptype`≠00, indexed by `id_pc`.
  - If `id_taken`: write tag, `tgt`=`id_target`, valid=1; counter saturating-increments, or is set to 2'b10 on a tag miss.
  - If not taken on a hit: counter saturating-decrements.
  - If not taken on a miss: no write.
  - Counters and valid bits reset to 2'b01 and 0.
- **Redirect.** Applies when `fb` & `id_error_pre`.
  - Fetch PC becomes `id_taken` ? `id_target` : `id_pc`+4.
  - `valid_o` clears at the next edge.
  - Any outstanding response is discarded.
  - A same-cycle training write to the same index still occurs.
- **FSM.**
  - RST → REQ: first cycle after reset deasserts.
  - REQ: `inst_req`=1.
    - On `inst_valid` & ~`stall_i` & no redirect: latch the output registers and advance the PC.
    - On `inst_valid` & `stall_i`: latch into a one-entry skid buffer and go to HOLD with `inst_req`=0.
  - HOLD: when `stall_i` falls, move the buffer to the outputs and return to REQ at the advanced PC.
  - KILL: entered on a redirect while a request is outstanding with no response that cycle. `inst_req`=0. The next `inst_valid` is dropped, then go to REQ at the redirect PC.
  - A redirect in the same cycle as `inst_valid` drops the data and goes directly to REQ.
  - A redirect in HOLD clears the buffer and goes to REQ.
- **Output register.**
  - When `stall_i`=1, every output register holds.
  - When `stall_i`=0 and no new instruction is accepted, `valid_o`=0 and `instr_o`=NOP.

## Timing
- Reset values:
  - `inst_req`=0, `inst_addr`=RESET_PC, `valid_o`=0.
  - `pc_o`=0, `instr_o`=NOP, `pre_jump_o`=0, `pre_branch_o`=0.
  - FSM=RST.
- Fetch-to-output latency: `valid_o` rises on the edge that samples `inst_valid`.
- With 1-cycle memory and no stalls, throughput is one instruction every 2 cycles: a REQ, then the response.
- Redirect penalty: `inst_addr` equals the redirect PC no later than 1 cycle after the redirect edge, or 1 cycle after the dropped response when in KILL.
- A prediction uses table state from before the same-cycle training write; there is no bypass.
- Asynchronous reset asserted mid-transaction forces the reset values immediately. Any later `inst_valid` for the killed request is ignored.

## Test plan
- **Reset.** Hold reset low for 3 cycles, then release. Required: `inst_req`=0 during reset; then `inst_req`=1 with `inst_addr`=0x8000_0000; `valid_o`=0 until the first response.
- **Sequential fetch.** 1-cycle memory returns 0x00100093 then 0x00200113. Required: `pc_o`=0x8000_0000 then 0x8000_0004, `pre_jump_o`=0.
- **Training.** Decode reports `id_pc`=0x8000_0010, type 01, taken to 0x8000_0040. Required: the next fetch of 0x8000_0010 gives `pre_jump_o`=1, `pre_branch_o`=0x8000_0040, and the following `inst_addr`=0x8000_0040. Then report not-taken twice. Required: `pre_jump_o`=0.
- **Redirect while outstanding.** Set `id_error_pre`=1, `id_taken`=1, `id_target`=0x8000_0100 while a 3-cycle-latency request is pending. Required: the stale response is dropped, the next `inst_addr`=0x8000_0100, and `valid_o`=0 until its response.
- **Stall.** Hold `stall_i` high for 3 cycles, with a response arriving in the first. Required: the outputs hold; `inst_req`=0 in HOLD; on release the buffered instruction appears in one cycle with the correct `pc_o`.
- **Qualification and mid-transaction reset.** Assert `id_error_pre` with `stall_i`=1. Required: no redirect and no training. Assert reset mid-transaction. Required: outputs go to their reset values immediately and the late `inst_valid` is ignored.
